// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor (a - b - bin), LSB first,
//            one full-subtractor cell plus a borrow flop, start/busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_borrow;
    logic               r_a_msb;
    logic               r_b_msb;

    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;
    logic               r_zero;

    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_borrow_nxt;
    logic [WIDTH-1:0]   w_res_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The DONE exit edge doubles as an accept slot so a held start yields
    // one operation every WIDTH+1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_RUN;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_x          = r_a[0];
        w_y          = r_b[0];
        w_d          = w_x ^ w_y ^ r_borrow;
        w_borrow_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
        w_res_nxt    = {w_d, r_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_res    <= '0;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (r_state == c_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrow_nxt;
            r_res    <= w_res_nxt;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            // Visible results change only on the final bit edge.
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_borrow_nxt;
                r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                r_zero <= (w_res_nxt == '0);
            end
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench: directed vector table, handshake corner
//            sequences and randomized operations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] m_diff;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] e_diff;
        logic         e_bout;
        logic         e_ovf;
        logic         e_zero;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: unsigned subtraction in W+1 bits gives diff and borrow.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                             output logic [W-1:0] d, output logic bo, output logic ov,
                             output logic z);
        logic [W:0] full;
        full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
        d    = full[W-1:0];
        bo   = full[W];
        ov   = (ra[W-1] != rb[W-1]) && (d[W-1] != ra[W-1]);
        z    = (d == '0);
    endtask

    // Called one time step after a rising edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input string tag);
        logic [W-1:0] ed;
        logic         eb, eo, ez;
        int           lat, bc;
        logic         toggled;
        ref_model(ta, tb_v, tbin, ed, eb, eo, ez);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = 0; bc = 0; toggled = 1'b0;
        while (!done && lat < 4 * W) begin
            if (busy) bc++;
            if (diff !== m_diff) toggled = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, W);
        chk({tag, " busy_cycles"}, bc, W);
        chk({tag, " diff_hold"}, {31'd0, toggled}, 0);
        chk({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, " bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, " zero"}, {31'd0, zero}, {31'd0, ez});
        m_diff = ed;
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, {30'd0, done, busy}, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int d1, d2, nd, cyc;
        logic [W-1:0] ra, rb;
        logic         rbin;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        m_diff = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {26'd0, busy, done, bout, ovf, zero, |diff}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: outputs checked against constants, then the model.
        for (int i = 0; i < 7; i++) begin
            logic [W-1:0] md;
            logic         mb, mo, mz;
            ref_model(vecs[i].a, vecs[i].b, vecs[i].bin, md, mb, mo, mz);
            chk($sformatf("vec%0d table", i), {29'd0, mb, mo, mz},
                {29'd0, vecs[i].e_bout, vecs[i].e_ovf, vecs[i].e_zero});
            chk($sformatf("vec%0d table_diff", i), {24'd0, md}, {24'd0, vecs[i].e_diff});
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i));
        end

        // start pulse during RUN must be ignored.
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 8'hF0; b = 8'h01; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ignore_start done_seen", {31'd0, done}, 1);
        chk("ignore_start diff", {24'd0, diff}, 32'h22);
        m_diff = 8'h22;
        @(posedge clk); #1;
        chk("ignore_start idle", {30'd0, done, busy}, 0);

        // Held start: back-to-back operations.
        a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
        d1 = -1; d2 = -1; nd = 0;
        for (cyc = 0; cyc < 4 * (W + 1) && nd < 2; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd == 0) d1 = cyc; else d2 = cyc;
                nd++;
                chk($sformatf("held diff%0d", nd), {24'd0, diff}, 32'h1B);
            end
        end
        start = 1'b0;
        chk("held done_count", nd, 2);
        chk("held first_latency", d1, W);
        chk("held period", d2 - d1, W + 1);
        m_diff = 8'h1B;
        @(posedge clk); #1;
        chk("held idle", {30'd0, done, busy}, 0);

        // Reset in the middle of an operation.
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst outputs", {26'd0, busy, done, bout, ovf, zero, |diff}, 0);
        nd = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("midrun_rst no_done", nd, 0);
        m_diff = '0;
        run_op(8'h10, 8'h01, 1'b0, "post_rst");

        // Randomized operations.
        for (int k = 0; k < 1000; k++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            if (k % 50 == 0) rb = ra;
            run_op(ra, rb, rbin, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
